// File: rtl/sram32_arb_pkg.sv
// Shared constants for the two-port sram32 arbiter.
// Holds the FSM state encodings and the port-id constants.
package sram32_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram32.sv
// Single-port 32-bit synchronous SRAM with byte enables.
// Ports: clk, rd, we, byte_en[3:0], addr, wdata[31:0] in; rdata[31:0] out (one-cycle read latency).
module sram32 #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rd,
    input  logic                  we,
    input  logic [3:0]            byte_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd) rdata <= mem[addr];
    end

endmodule

// File: rtl/sram32_arb.sv
// Two-port round-robin arbiter with bounded locking in front of one sram32.
// Ports: clk, rst; per port pN_req/lock/we/be/addr/wdata in, pN_ack/rvalid/rdata out;
// sram_rd/we/byte_en/addr/wdata out and sram_rdata in, wired straight to the SRAM.
module sram32_arb
    import sram32_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_LOCK   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_lock,
    input  logic                  p0_we,
    input  logic [3:0]            p0_be,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [31:0]           p0_wdata,
    output logic                  p0_ack,
    output logic                  p0_rvalid,
    output logic [31:0]           p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_lock,
    input  logic                  p1_we,
    input  logic [3:0]            p1_be,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [31:0]           p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_rvalid,
    output logic [31:0]           p1_rdata,
    output logic                  sram_rd,
    output logic                  sram_we,
    output logic [3:0]            sram_byte_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    state_t     state, state_nxt;
    logic [3:0] lock_cnt, lock_cnt_nxt;
    logic       last_grant, last_grant_nxt;
    logic       rvalid0_q, rvalid1_q;

    logic       grant_any;
    logic       grant_id;
    logic       win_lock;
    logic       win_we;
    logic [3:0] cnt_inc;
    logic       cnt_hit;
    logic       first_hit;

    // Grant decode: nothing is granted while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = PORT0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (p0_req && p1_req) begin
                        grant_any = 1'b1;
                        grant_id  = ~last_grant;
                    end else if (p0_req) begin
                        grant_any = 1'b1;
                        grant_id  = PORT0;
                    end else if (p1_req) begin
                        grant_any = 1'b1;
                        grant_id  = PORT1;
                    end
                end
                LOCK0: begin
                    grant_any = p0_req;
                    grant_id  = PORT0;
                end
                LOCK1: begin
                    grant_any = p1_req;
                    grant_id  = PORT1;
                end
                default: ;
            endcase
        end
    end

    assign win_lock  = (grant_id == PORT1) ? p1_lock : p0_lock;
    assign win_we    = (grant_id == PORT1) ? p1_we : p0_we;
    assign cnt_inc   = lock_cnt + 4'd1;
    assign cnt_hit   = (cnt_inc == 4'(MAX_LOCK));
    assign first_hit = (4'd1 == 4'(MAX_LOCK));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lock_cnt   <= 4'd0;
            last_grant <= PORT1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= lock_cnt_nxt;
            last_grant <= last_grant_nxt;
            rvalid0_q  <= grant_any && !win_we && (grant_id == PORT0);
            rvalid1_q  <= grant_any && !win_we && (grant_id == PORT1);
        end
    end

    // A forced exit at MAX_LOCK leaves last_grant on the lock owner,
    // which hands the next contended cycle to the other port.
    always_comb begin
        state_nxt      = state;
        lock_cnt_nxt   = lock_cnt;
        last_grant_nxt = grant_any ? grant_id : last_grant;
        unique case (state)
            IDLE: begin
                if (grant_any && win_lock && !first_hit) begin
                    state_nxt    = (grant_id == PORT1) ? LOCK1 : LOCK0;
                    lock_cnt_nxt = 4'd1;
                end
            end
            LOCK0, LOCK1: begin
                if (!grant_any || !win_lock || cnt_hit) begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = 4'd0;
                end else begin
                    lock_cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        p0_ack       = grant_any && (grant_id == PORT0);
        p1_ack       = grant_any && (grant_id == PORT1);
        sram_rd      = grant_any && !win_we;
        sram_we      = grant_any && win_we;
        sram_byte_en = 4'd0;
        sram_addr    = p0_addr;
        sram_wdata   = p0_wdata;
        if (grant_id == PORT1) begin
            sram_addr  = p1_addr;
            sram_wdata = p1_wdata;
        end
        if (grant_any) begin
            sram_byte_en = (grant_id == PORT1) ? p1_be : p0_be;
        end
        // Reset also hides a read that was in flight when it arrived.
        p0_rvalid = rvalid0_q && !rst;
        p1_rvalid = rvalid1_q && !rst;
        p0_rdata  = p0_rvalid ? sram_rdata : 32'd0;
        p1_rdata  = p1_rvalid ? sram_rdata : 32'd0;
    end

endmodule

// File: tb/tb_sram32_arb.sv
// Self-checking bench for sram32_arb driving a real sram32 instance.
module tb_sram32_arb;
    import sram32_arb_pkg::*;

    localparam int AW = 11;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_lock, p0_we;
    logic [3:0]    p0_be;
    logic [AW-1:0] p0_addr;
    logic [31:0]   p0_wdata;
    logic          p0_ack, p0_rvalid;
    logic [31:0]   p0_rdata;
    logic          p1_req, p1_lock, p1_we;
    logic [3:0]    p1_be;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_wdata;
    logic          p1_ack, p1_rvalid;
    logic [31:0]   p1_rdata;
    logic          sram_rd, sram_we;
    logic [3:0]    sram_byte_en;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int total = 0;
    int bad = 0;
    logic [31:0] mem_m [2**AW];

    always #5 clk = ~clk;

    sram32_arb #(.ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_be(p0_be),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_be(p1_be),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sram_rd(sram_rd), .sram_we(sram_we), .sram_byte_en(sram_byte_en),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    sram32 #(.ADDR_WIDTH(AW)) u_sram (
        .clk(clk), .rd(sram_rd), .we(sram_we), .byte_en(sram_byte_en),
        .addr(sram_addr), .wdata(sram_wdata), .rdata(sram_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p0_req = 0; p0_lock = 0; p0_we = 0; p0_be = 0; p0_addr = '0; p0_wdata = 0;
        p1_req = 0; p1_lock = 0; p1_we = 0; p1_be = 0; p1_addr = '0; p1_wdata = 0;
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic apply_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        bit got = 0;
        p0_req = 1; p0_we = 1; p0_be = 4'hF; p0_addr = AW'(a); p0_wdata = d;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (p0_ack) got = 1;
            tick();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL preload_ack addr=%0h got=0 exp=1", a);
        end
        mem_m[a] = d;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1;
        p0_req = 1; p1_req = 1; p1_we = 1; p1_be = 4'hF;
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({p0_ack, p1_ack} !== 2'b00) begin
            bad++; $display("FAIL reset_ack got=%b exp=00", {p0_ack, p1_ack});
        end
        total++;
        if ({sram_rd, sram_we, sram_byte_en} !== 6'd0) begin
            bad++; $display("FAIL reset_sram got=%b exp=0", {sram_rd, sram_we, sram_byte_en});
        end
        total++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            bad++; $display("FAIL reset_rvalid got=%b exp=00", {p0_rvalid, p1_rvalid});
        end
        total++;
        if (dut.state !== IDLE) begin
            bad++; $display("FAIL reset_state got=%0d exp=0", dut.state);
        end
        tick();
        clear_inputs();
        rst = 0;
    endtask

    task automatic test_idle();
        clear_inputs();
        tick();
        @(negedge clk);
        total++;
        if ({sram_rd, sram_we, sram_byte_en, p0_ack, p1_ack} !== 8'd0) begin
            bad++;
            $display("FAIL idle got=%b exp=0", {sram_rd, sram_we, sram_byte_en, p0_ack, p1_ack});
        end
        tick();
    endtask

    task automatic test_simul_read();
        p0_req = 1; p0_addr = 11'h010;
        p1_req = 1; p1_addr = 11'h020;
        @(negedge clk);
        total++;
        if ({p0_ack, p1_ack, sram_rd, sram_we} !== 4'b1010 || sram_addr !== 11'h010) begin
            bad++;
            $display("FAIL simul_c1 got=%b/%h exp=1010/010", {p0_ack, p1_ack, sram_rd, sram_we}, sram_addr);
        end
        tick();
        p0_req = 0;
        @(negedge clk);
        total++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hAABBCCDD) begin
            bad++; $display("FAIL simul_p0_data got=%b/%h exp=1/aabbccdd", p0_rvalid, p0_rdata);
        end
        total++;
        if ({p0_ack, p1_ack} !== 2'b01 || sram_addr !== 11'h020) begin
            bad++; $display("FAIL simul_c2 got=%b/%h exp=01/020", {p0_ack, p1_ack}, sram_addr);
        end
        tick();
        p1_req = 0;
        @(negedge clk);
        total++;
        if ({p1_rvalid, p0_rvalid} !== 2'b10 || p1_rdata !== 32'h11223344 || p0_rdata !== 32'd0) begin
            bad++;
            $display("FAIL simul_p1_data got=%b/%h/%h exp=10/11223344/0", {p1_rvalid, p0_rvalid}, p1_rdata, p0_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_byte_write();
        p1_req = 1; p1_we = 1; p1_be = 4'b0101; p1_addr = 11'h005; p1_wdata = 32'h12345678;
        @(negedge clk);
        total++;
        if ({p1_ack, sram_we, sram_rd} !== 3'b110 || sram_byte_en !== 4'b0101) begin
            bad++;
            $display("FAIL bw_write got=%b/%b exp=110/0101", {p1_ack, sram_we, sram_rd}, sram_byte_en);
        end
        mem_m[5] = merge(mem_m[5], 32'h12345678, 4'b0101);
        tick();
        p1_we = 0;
        @(negedge clk);
        total++;
        if (p1_rvalid !== 1'b0 || p1_ack !== 1'b1) begin
            bad++; $display("FAIL bw_no_rvalid got=%b%b exp=01", p1_rvalid, p1_ack);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        total++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hFF34FF78) begin
            bad++; $display("FAIL bw_read got=%b/%h exp=1/ff34ff78", p1_rvalid, p1_rdata);
        end
        tick();
    endtask

    task automatic test_lock();
        p0_req = 1; p0_lock = 1; p0_addr = 11'h020;
        p1_req = 1; p1_addr = 11'h010;
        for (int c = 1; c <= 6; c++) begin
            logic [1:0] exp;
            exp = (c == 5) ? 2'b01 : 2'b10;
            @(negedge clk);
            total++;
            if ({p0_ack, p1_ack} !== exp) begin
                bad++; $display("FAIL lock_c%0d got=%b exp=%b", c, {p0_ack, p1_ack}, exp);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i <= 8; i++) begin
            p0_req = (i < 8); p0_addr = AW'(i);
            @(negedge clk);
            if (i < 8) begin
                total++;
                if (p0_ack !== 1'b1) begin
                    bad++; $display("FAIL stream_ack%0d got=%b exp=1", i, p0_ack);
                end
            end
            total++;
            if (i == 0) begin
                if (p0_rvalid !== 1'b0) begin
                    bad++; $display("FAIL stream_rv0 got=%b exp=0", p0_rvalid);
                end
            end else if (p0_rvalid !== 1'b1 || p0_rdata !== mem_m[i-1]) begin
                bad++;
                $display("FAIL stream_data%0d got=%b/%h exp=1/%h", i - 1, p0_rvalid, p0_rdata, mem_m[i-1]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        p1_req = 1; p1_addr = 11'h020;
        @(negedge clk);
        total++;
        if (p1_ack !== 1'b1) begin
            bad++; $display("FAIL rmr_ack got=%b exp=1", p1_ack);
        end
        tick();
        p1_req = 0;
        rst = 1;
        @(negedge clk);
        total++;
        if (p1_rvalid !== 1'b0) begin
            bad++; $display("FAIL rmr_rvalid_in got=%b exp=0", p1_rvalid);
        end
        tick();
        rst = 0;
        @(negedge clk);
        total++;
        if (p1_rvalid !== 1'b0 || dut.state !== IDLE) begin
            bad++; $display("FAIL rmr_after got=%b/%0d exp=0/0", p1_rvalid, dut.state);
        end
        tick();
        p0_req = 1; p1_req = 1;
        @(negedge clk);
        total++;
        if ({p0_ack, p1_ack} !== 2'b10) begin
            bad++; $display("FAIL rmr_contend got=%b exp=10", {p0_ack, p1_ack});
        end
        tick();
        clear_inputs();
    endtask

    // Reference: 'owner' is the port holding a lock (-1 if none), 'run' counts
    // its grants, 'prefer' is the port that wins the next contended cycle.
    task automatic test_random();
        int owner = -1;
        int run = 0;
        int prefer = 0;
        bit exp_rv [2] = '{0, 0};
        logic [31:0] exp_rd [2] = '{0, 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit req [2], lk [2], wr [2];
            logic [3:0] be [2];
            int ad [2];
            logic [31:0] wd [2];
            int win;
            logic [3:0] exp_be;
            for (int p = 0; p < 2; p++) begin
                req[p] = ($urandom_range(0, 3) != 0);
                lk[p] = $urandom_range(0, 1) == 1;
                wr[p] = ($urandom_range(0, 2) == 0);
                be[p] = 4'($urandom_range(0, 15));
                ad[p] = $urandom_range(0, 15);
                wd[p] = $urandom;
            end
            p0_req = req[0]; p0_lock = lk[0]; p0_we = wr[0]; p0_be = be[0];
            p0_addr = AW'(ad[0]); p0_wdata = wd[0];
            p1_req = req[1]; p1_lock = lk[1]; p1_we = wr[1]; p1_be = be[1];
            p1_addr = AW'(ad[1]); p1_wdata = wd[1];
            if (owner >= 0) win = req[owner] ? owner : -1;
            else if (req[0] && req[1]) win = prefer;
            else if (req[0]) win = 0;
            else if (req[1]) win = 1;
            else win = -1;
            exp_be = (win >= 0) ? be[win] : 4'd0;
            @(negedge clk);
            total++;
            if ({p0_ack, p1_ack} !== {win == 0, win == 1}) begin
                bad++; $display("FAIL rnd_ack c%0d got=%b exp=%b", cyc, {p0_ack, p1_ack}, {win == 0, win == 1});
            end
            total++;
            if ({sram_rd, sram_we, sram_byte_en} !== {win >= 0 && !wr[win], win >= 0 && wr[win], exp_be}
                || (win >= 0 && sram_addr !== AW'(ad[win]))) begin
                bad++; $display("FAIL rnd_sram c%0d got=%b%b%b/%h", cyc, sram_rd, sram_we, sram_byte_en, sram_addr);
            end
            total++;
            if ({p0_rvalid, p1_rvalid} !== {exp_rv[0], exp_rv[1]}
                || p0_rdata !== (exp_rv[0] ? exp_rd[0] : 32'd0)
                || p1_rdata !== (exp_rv[1] ? exp_rd[1] : 32'd0)) begin
                bad++;
                $display("FAIL rnd_rdata c%0d got=%b%b/%h/%h exp=%b%b/%h/%h", cyc, p0_rvalid, p1_rvalid,
                         p0_rdata, p1_rdata, exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]);
            end
            for (int p = 0; p < 2; p++) exp_rv[p] = (win == p) && !wr[p];
            if (win >= 0) begin
                prefer = 1 - win;
                if (wr[win]) mem_m[ad[win]] = merge(mem_m[ad[win]], wd[win], be[win]);
                else exp_rd[win] = mem_m[ad[win]];
            end
            if (owner < 0) begin
                if (win >= 0 && lk[win]) begin
                    run = 1;
                    owner = (run >= ML) ? -1 : win;
                end
            end else if (win < 0) begin
                owner = -1;
            end else begin
                run++;
                if (!lk[win] || run >= ML) owner = -1;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        for (int a = 0; a < 16; a++) preload(a, 32'hC0DE0000 + 32'(a * 32'h111));
        preload(5, 32'hFFFFFFFF);
        preload(16, 32'hAABBCCDD);
        preload(32, 32'h11223344);
        apply_reset();
        test_idle();
        test_simul_read();
        test_byte_write();
        apply_reset();
        test_lock();
        test_stream();
        test_reset_mid_read();
        apply_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
